guess_game_ctrl: RTL and testbench



---
 rtl/guess_game_ctrl_pkg.sv | 23 ++
 rtl/guess_game_ctrl_if.sv | 33 +++
 rtl/guess_game_ctrl_lfsr16.sv | 19 +
 rtl/guess_game_ctrl.sv | 144 ++++++++++++++
 tb/tb_guess_game_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/guess_game_ctrl_pkg.sv
// Shared types, hint encodings and digit helper for the guessing-game controller.
package guess_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GEN       = 3'd1,
        GUESS     = 3'd2,
        CHECK     = 3'd3,
        ROUND_WIN = 3'd4,
        GAME_WIN  = 3'd5,
        GAME_LOSE = 3'd6
    } game_state_t;

    localparam logic [1:0] HINT_LOWER  = 2'd0;
    localparam logic [1:0] HINT_HIGHER = 2'd1;
    localparam logic [1:0] HINT_NONE   = 2'd3;

    // Map a raw 4-bit random nibble onto a decimal digit 0..9.
    function automatic logic [3:0] bcd_fold(input logic [3:0] nibble);
        return (nibble > 4'd9) ? nibble - 4'd10 : nibble;
    endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Button/digit inputs and display-facing outputs of the game controller.
interface guess_game_ctrl_if;

    logic       start_btn;
    logic       confirm_btn;
    logic [3:0] key0;
    logic [3:0] key1;
    logic [3:0] key2;
    logic [3:0] answer0;
    logic [3:0] answer1;
    logic [3:0] answer2;
    logic [1:0] max_digit;
    logic [1:0] hint;
    logic [2:0] round;
    logic [2:0] incorrect_guess;
    logic       game_over;
    logic       win;

    // Player side: buttons and keypad digits in, game status out.
    modport master (
        output start_btn, confirm_btn, key0, key1, key2,
        input  answer0, answer1, answer2, max_digit, hint, round,
               incorrect_guess, game_over, win
    );

    // Controller side.
    modport slave (
        input  start_btn, confirm_btn, key0, key1, key2,
        output answer0, answer1, answer2, max_digit, hint, round,
               incorrect_guess, game_over, win
    );

endinterface

// File: rtl/guess_game_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the answer source.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Shift every cycle; reload the nonzero seed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// Game sequencer: answer generation, guess compare, hint, round and wrong-guess tracking.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned MAX_WRONG  = 5,
    parameter int unsigned NUM_ROUNDS = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic              clk,
    input logic              reset,
    guess_game_ctrl_if.slave bus
);

    localparam logic [2:0] MAX_WRONG_C  = 3'(MAX_WRONG);
    localparam logic [2:0] NUM_ROUNDS_C = 3'(NUM_ROUNDS);

    logic [15:0] lfsr;
    logic [3:0]  lfsr_unused;

    game_state_t state;
    logic        start_prev;
    logic        confirm_prev;
    logic        start_p;
    logic        confirm_p;
    logic [3:0]  guess0;
    logic [3:0]  guess1;
    logic [3:0]  guess2;
    logic [3:0]  answer0_q;
    logic [3:0]  answer1_q;
    logic [3:0]  answer2_q;
    logic [1:0]  max_digit_q;
    logic [1:0]  hint_q;
    logic [2:0]  round_q;
    logic [2:0]  incorrect_q;

    logic        key_invalid;
    logic        guess_gt;
    logic        guess_lt;
    logic [2:0]  incorrect_inc;
    logic [2:0]  round_inc;
    logic [1:0]  max_digit_inc;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    // Only the low three nibbles feed the answer digits.
    assign lfsr_unused = lfsr[15:12];

    // Validity of active keypad digits, compare of masked BCD values, saturating increments.
    always_comb begin
        key_invalid = (bus.key0 > 4'd9);
        if ((max_digit_q >= 2'd2) && (bus.key1 > 4'd9)) key_invalid = 1'b1;
        if ((max_digit_q == 2'd3) && (bus.key2 > 4'd9)) key_invalid = 1'b1;
        // Concatenated valid BCD digits order the same as the decimal values (MSB digit first).
        guess_gt      = {guess2, guess1, guess0} > {answer2_q, answer1_q, answer0_q};
        guess_lt      = {guess2, guess1, guess0} < {answer2_q, answer1_q, answer0_q};
        incorrect_inc = incorrect_q + 3'd1;
        round_inc     = (round_q == 3'd7) ? 3'd7 : round_q + 3'd1;
        max_digit_inc = (max_digit_q == 2'd3) ? 2'd3 : max_digit_q + 2'd1;
    end

    // Button edge detection plus the game FSM; a start pulse restarts from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            start_prev   <= 1'b0;
            confirm_prev <= 1'b0;
            start_p      <= 1'b0;
            confirm_p    <= 1'b0;
            guess0       <= '0;
            guess1       <= '0;
            guess2       <= '0;
            answer0_q    <= '0;
            answer1_q    <= '0;
            answer2_q    <= '0;
            max_digit_q  <= 2'd1;
            hint_q       <= HINT_NONE;
            round_q      <= '0;
            incorrect_q  <= '0;
        end else begin
            start_prev   <= bus.start_btn;
            confirm_prev <= bus.confirm_btn;
            start_p      <= bus.start_btn & ~start_prev;
            confirm_p    <= bus.confirm_btn & ~confirm_prev;

            if (start_p) begin
                round_q     <= '0;
                max_digit_q <= 2'd1;
                state       <= GEN;
            end else begin
                case (state)
                    GEN: begin
                        answer0_q   <= bcd_fold(lfsr[3:0]);
                        answer1_q   <= (max_digit_q >= 2'd2) ? bcd_fold(lfsr[7:4]) : 4'd0;
                        answer2_q   <= (max_digit_q == 2'd3) ? bcd_fold(lfsr[11:8]) : 4'd0;
                        incorrect_q <= '0;
                        hint_q      <= HINT_NONE;
                        state       <= GUESS;
                    end
                    GUESS: begin
                        if (confirm_p && !key_invalid) begin
                            guess0 <= bus.key0;
                            guess1 <= (max_digit_q >= 2'd2) ? bus.key1 : 4'd0;
                            guess2 <= (max_digit_q == 2'd3) ? bus.key2 : 4'd0;
                            state  <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (guess_gt || guess_lt) begin
                            hint_q      <= guess_gt ? HINT_LOWER : HINT_HIGHER;
                            incorrect_q <= incorrect_inc;
                            state       <= (incorrect_inc == MAX_WRONG_C) ? GAME_LOSE : GUESS;
                        end else begin
                            hint_q <= HINT_NONE;
                            state  <= ROUND_WIN;
                        end
                    end
                    ROUND_WIN: begin
                        round_q     <= round_inc;
                        max_digit_q <= max_digit_inc;
                        state       <= (round_inc == NUM_ROUNDS_C) ? GAME_WIN : GEN;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign bus.answer0         = answer0_q;
    assign bus.answer1         = answer1_q;
    assign bus.answer2         = answer2_q;
    assign bus.max_digit       = max_digit_q;
    assign bus.hint            = hint_q;
    assign bus.round           = round_q;
    assign bus.incorrect_guess = incorrect_q;
    assign bus.game_over       = (state == GAME_WIN) || (state == GAME_LOSE);
    assign bus.win             = (state == GAME_WIN);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed self-checking bench for guess_game_ctrl.
module tb_guess_game_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [15:0] m_lfsr;
    logic [3:0]  e0, e1, e2;
    int          exp_md;

    guess_game_ctrl_if bus ();

    guess_game_ctrl #(
        .MAX_WRONG  (5),
        .NUM_ROUNDS (3),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting every cycle.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] fold(input logic [3:0] n);
        if (n >= 4'd10) return n - 4'd10;
        return n;
    endfunction

    function automatic int ans_val();
        return int'(e2) * 100 + int'(e1) * 10 + int'(e0);
    endfunction

    function automatic int mod_val();
        return (exp_md == 1) ? 10 : (exp_md == 2) ? 100 : 1000;
    endfunction

    // Expected answers from the reference LFSR value the DUT will latch on the next edge.
    task automatic snap();
        logic [15:0] v;
        v  = m_lfsr;
        e0 = fold(v[3:0]);
        e1 = (exp_md >= 2) ? fold(v[7:4]) : 4'd0;
        e2 = (exp_md >= 3) ? fold(v[11:8]) : 4'd0;
    endtask

    // Start press; returns 1 ns after the GEN edge. With hold set, start_btn stays high.
    task automatic press_start(input bit hold);
        @(negedge clk);
        bus.start_btn = 1'b1;
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            bus.start_btn = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_md = 1;
        snap();
        @(posedge clk);
        #1;
    endtask

    // Submit a guess; returns 1 ns after the edge where hint/incorrect_guess update.
    task automatic submit(input int g);
        @(negedge clk);
        bus.key0        = 4'(g % 10);
        bus.key1        = 4'((g / 10) % 10);
        bus.key2        = 4'((g / 100) % 10);
        bus.confirm_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.confirm_btn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.hint !== 2'd3) begin failures++; $display("FAIL reset_hint got=%0d exp=3", bus.hint); end
        checks++; if (bus.round !== 3'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", bus.round); end
        checks++; if (bus.max_digit !== 2'd1) begin failures++; $display("FAIL reset_max_digit got=%0d exp=1", bus.max_digit); end
        checks++; if (bus.incorrect_guess !== 3'd0) begin failures++; $display("FAIL reset_incorrect got=%0d exp=0", bus.incorrect_guess); end
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== 12'h000) begin failures++; $display("FAIL reset_answers got=%h exp=000", {bus.answer2, bus.answer1, bus.answer0}); end
        checks++; if ({bus.game_over, bus.win} !== 2'b00) begin failures++; $display("FAIL reset_over_win got=%b exp=00", {bus.game_over, bus.win}); end
    endtask

    task automatic test_start_hold();
        press_start(1'b1);
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL start_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
        checks++; if ({bus.answer2, bus.answer1} !== 8'h00 || bus.answer0 > 4'd9) begin failures++; $display("FAIL start_digit_range got=%h exp=00x(x<=9)", {bus.answer2, bus.answer1, bus.answer0}); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL start_held_single_gen got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
        @(negedge clk);
        bus.start_btn = 1'b0;
    endtask

    task automatic test_round_one();
        int a, g;
        a = ans_val();
        for (int k = 1; k <= 2; k++) begin
            g = (a + k) % mod_val();
            submit(g);
            checks++; if (bus.hint !== ((g > a) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL r1_hint_%0d got=%0d exp=%0d", k, bus.hint, (g > a) ? 0 : 1); end
            checks++; if (bus.incorrect_guess !== 3'(k)) begin failures++; $display("FAIL r1_incorrect_%0d got=%0d exp=%0d", k, bus.incorrect_guess, k); end
        end
        submit(a);
        checks++; if (bus.hint !== 2'd3) begin failures++; $display("FAIL r1_correct_hint got=%0d exp=3", bus.hint); end
        checks++; if (bus.incorrect_guess !== 3'd2) begin failures++; $display("FAIL r1_correct_incorrect got=%0d exp=2", bus.incorrect_guess); end
        @(posedge clk);
        #1;
        checks++; if (bus.round !== 3'd1) begin failures++; $display("FAIL r1_round got=%0d exp=1", bus.round); end
        checks++; if (bus.max_digit !== 2'd2) begin failures++; $display("FAIL r1_max_digit got=%0d exp=2", bus.max_digit); end
        exp_md = 2;
        snap();
        @(posedge clk);
        #1;
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL r2_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
        checks++; if (bus.incorrect_guess !== 3'd0) begin failures++; $display("FAIL r2_incorrect_clear got=%0d exp=0", bus.incorrect_guess); end
    endtask

    task automatic test_holdoff();
        int a, g;
        a = ans_val();
        @(negedge clk);
        bus.key0 = 4'd0;
        bus.key1 = 4'hC;
        bus.key2 = 4'd0;
        bus.confirm_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.confirm_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.incorrect_guess !== 3'd0) begin failures++; $display("FAIL holdoff_incorrect got=%0d exp=0", bus.incorrect_guess); end
        checks++; if (bus.hint !== 2'd3) begin failures++; $display("FAIL holdoff_hint got=%0d exp=3", bus.hint); end
        g = (a + 1) % mod_val();
        submit(g);
        checks++; if (bus.incorrect_guess !== 3'd1) begin failures++; $display("FAIL r2_wrong_incorrect got=%0d exp=1", bus.incorrect_guess); end
        checks++; if (bus.hint !== ((g > a) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL r2_wrong_hint got=%0d exp=%0d", bus.hint, (g > a) ? 0 : 1); end
        submit(a);
        @(posedge clk);
        #1;
        checks++; if ({bus.round, bus.max_digit} !== {3'd2, 2'd3}) begin failures++; $display("FAIL r2_advance got=%0d/%0d exp=2/3", bus.round, bus.max_digit); end
        exp_md = 3;
        snap();
        @(posedge clk);
        #1;
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL r3_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
    endtask

    task automatic test_three_digit_win();
        int a, g;
        a = ans_val();
        // Swap tens and ones (e.g. 407 -> 470) when that gives a different value.
        if (e1 != e0) g = int'(e2) * 100 + int'(e0) * 10 + int'(e1);
        else          g = (a + 1) % mod_val();
        submit(g);
        checks++; if (bus.hint !== ((g > a) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL r3_hint got=%0d exp=%0d (g=%0d a=%0d)", bus.hint, (g > a) ? 0 : 1, g, a); end
        checks++; if (bus.incorrect_guess !== 3'd1) begin failures++; $display("FAIL r3_incorrect got=%0d exp=1", bus.incorrect_guess); end
        submit(a);
        checks++; if (bus.game_over !== 1'b0) begin failures++; $display("FAIL r3_over_early got=%b exp=0", bus.game_over); end
        @(posedge clk);
        #1;
        checks++; if ({bus.win, bus.game_over} !== 2'b11) begin failures++; $display("FAIL win_flags got=%b exp=11", {bus.win, bus.game_over}); end
        checks++; if ({bus.round, bus.max_digit} !== {3'd3, 2'd3}) begin failures++; $display("FAIL win_round_md got=%0d/%0d exp=3/3", bus.round, bus.max_digit); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL win_answers_held got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
    endtask

    task automatic test_lose();
        int a, g;
        logic [1:0] last_hint;
        press_start(1'b0);
        checks++; if ({bus.round, bus.max_digit, bus.game_over, bus.win} !== {3'd0, 2'd1, 2'b00}) begin failures++; $display("FAIL restart_from_win got=%0d/%0d/%b%b exp=0/1/00", bus.round, bus.max_digit, bus.game_over, bus.win); end
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL lose_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
        a = ans_val();
        last_hint = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            g = (a + k) % mod_val();
            last_hint = (g > a) ? 2'd0 : 2'd1;
            submit(g);
            checks++; if (bus.incorrect_guess !== 3'(k)) begin failures++; $display("FAIL lose_incorrect_%0d got=%0d exp=%0d", k, bus.incorrect_guess, k); end
            checks++; if (bus.game_over !== (k == 5)) begin failures++; $display("FAIL lose_over_%0d got=%b exp=%b", k, bus.game_over, k == 5); end
        end
        checks++; if (bus.win !== 1'b0) begin failures++; $display("FAIL lose_win got=%b exp=0", bus.win); end
        submit(a);
        checks++; if ({bus.incorrect_guess, bus.hint, bus.game_over} !== {3'd5, last_hint, 1'b1}) begin failures++; $display("FAIL lose_frozen got=%0d/%0d/%b exp=5/%0d/1", bus.incorrect_guess, bus.hint, bus.game_over, last_hint); end
    endtask

    task automatic test_restart_priority();
        int a, g;
        press_start(1'b0);
        submit(ans_val());
        @(posedge clk);
        #1;
        exp_md = 2;
        snap();
        @(posedge clk);
        #1;
        checks++; if ({bus.round, bus.max_digit} !== {3'd1, 2'd2}) begin failures++; $display("FAIL prio_setup got=%0d/%0d exp=1/2", bus.round, bus.max_digit); end
        a = ans_val();
        submit((a + 1) % mod_val());
        g = (a + 2) % mod_val();
        @(negedge clk);
        bus.key0 = 4'(g % 10);
        bus.key1 = 4'((g / 10) % 10);
        bus.start_btn   = 1'b1;
        bus.confirm_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_btn   = 1'b0;
        bus.confirm_btn = 1'b0;
        @(posedge clk);
        #1;
        exp_md = 1;
        snap();
        @(posedge clk);
        #1;
        checks++; if ({bus.incorrect_guess, bus.hint} !== {3'd0, 2'd3}) begin failures++; $display("FAIL prio_restart got=%0d/%0d exp=0/3", bus.incorrect_guess, bus.hint); end
        checks++; if ({bus.round, bus.max_digit} !== {3'd0, 2'd1}) begin failures++; $display("FAIL prio_round got=%0d/%0d exp=0/1", bus.round, bus.max_digit); end
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL prio_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
    endtask

    task automatic test_reset_in_check();
        int a, g;
        a = ans_val();
        submit((a + 1) % mod_val());
        g = (a + 2) % mod_val();
        @(negedge clk);
        bus.key0 = 4'(g % 10);
        bus.key1 = 4'd0;
        bus.key2 = 4'd0;
        bus.confirm_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.confirm_btn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.hint, bus.incorrect_guess, bus.round, bus.max_digit} !== {2'd3, 3'd0, 3'd0, 2'd1}) begin failures++; $display("FAIL rst_check_ctrs got=%0d/%0d/%0d/%0d exp=3/0/0/1", bus.hint, bus.incorrect_guess, bus.round, bus.max_digit); end
        checks++; if ({bus.answer2, bus.answer1, bus.answer0, bus.game_over, bus.win} !== 14'h0) begin failures++; $display("FAIL rst_check_outs got=%h/%b%b exp=000/00", {bus.answer2, bus.answer1, bus.answer0}, bus.game_over, bus.win); end
        @(negedge clk);
        reset = 1'b0;
        submit(g);
        checks++; if ({bus.hint, bus.incorrect_guess} !== {2'd3, 3'd0}) begin failures++; $display("FAIL idle_confirm got=%0d/%0d exp=3/0", bus.hint, bus.incorrect_guess); end
        press_start(1'b0);
        checks++; if ({bus.answer2, bus.answer1, bus.answer0} !== {e2, e1, e0}) begin failures++; $display("FAIL post_reset_answers got=%h exp=%h", {bus.answer2, bus.answer1, bus.answer0}, {e2, e1, e0}); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        exp_md          = 1;
        reset           = 1'b1;
        bus.start_btn   = 1'b0;
        bus.confirm_btn = 1'b0;
        bus.key0        = 4'd0;
        bus.key1        = 4'd0;
        bus.key2        = 4'd0;
        test_reset();
        test_start_hold();
        test_round_one();
        test_holdoff();
        test_three_digit_win();
        test_lose();
        test_restart_priority();
        test_reset_in_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
